// File: rtl/flood_pkg.sv
// Shared types and constants for the Flood-It game-state engine.
// Board geometry, colour/index types and the engine state encoding.
package flood_pkg;

   localparam int MAX_SIZE = 26;
   localparam int COLOR_W  = 3;
   localparam int IDX_W    = 5;
   localparam int CNT_W    = 10;

   typedef logic [IDX_W-1:0]   idx_t;
   typedef logic [COLOR_W-1:0] color_t;

   localparam idx_t MAX_IDX = idx_t'(MAX_SIZE);
   localparam idx_t MIN_IDX = idx_t'(2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GROW,
      ST_PLAY,
      ST_RECOLOR,
      ST_CHECK,
      ST_DONE
   } state_t;

   // A board smaller than 2x2 or larger than the storage is never played.
   function automatic idx_t clamp_size(input idx_t s);
      if (s < MIN_IDX) return MIN_IDX;
      if (s > MAX_IDX) return MAX_IDX;
      return s;
   endfunction

endpackage

// File: rtl/flood_sweep_ctr.sv
// Raster-order row/column walker over a size x size board.
// Holds at (0,0) while disabled and wraps to (0,0) after the last cell.
module flood_sweep_ctr
   import flood_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  idx_t size,
   output idx_t row,
   output idx_t col,
   output logic last
);

   idx_t row_reg;
   idx_t col_reg;
   logic col_last;

   assign col_last = (col_reg == size - idx_t'(1));
   assign last     = col_last && (row_reg == size - idx_t'(1));
   assign row      = row_reg;
   assign col      = col_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (!en || last) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (col_last) begin
         row_reg <= row_reg + idx_t'(1);
         col_reg <= '0;
      end else begin
         col_reg <= col_reg + idx_t'(1);
      end
   end

endmodule

// File: rtl/flood_fill_engine.sv
// Flood-It game state: live board, flood region grown from (0,0) by raster
// sweeps, move counting and win/loss detection.
module flood_fill_engine
   import flood_pkg::*;
#(
   parameter int MOVE_W = 6
) (
   input  logic              FAST_CLOCK,
   input  logic              RESET_N,
   input  idx_t              SIZE,
   input  logic [MOVE_W-1:0] MOVE_MAX,
   input  logic              LOAD_EN,
   input  idx_t              LOAD_ROW,
   input  idx_t              LOAD_COL,
   input  color_t            LOAD_COLOR,
   input  logic              START,
   input  logic              MOVE_VALID,
   input  color_t            MOVE_COLOR,
   output logic              MOVE_READY,
   input  idx_t              RD_ROW,
   input  idx_t              RD_COL,
   output color_t            RD_COLOR,
   output logic [MOVE_W-1:0] MOVES,
   output logic              BUSY,
   output logic              WON,
   output logic              LOST
);

   state_t             state_reg, state_next;
   color_t             color_reg   [MAX_SIZE][MAX_SIZE];
   logic               flooded_reg [MAX_SIZE][MAX_SIZE];
   idx_t               size_reg;
   logic [MOVE_W-1:0]  move_max_reg;
   logic [MOVE_W-1:0]  moves_reg;
   color_t             cur_reg;
   logic [CNT_W-1:0]   flood_cnt_reg;
   logic               changed_reg;
   logic               won_reg;
   logic               lost_reg;

   idx_t               sw_row, sw_col;
   logic               sw_last, sw_en;
   logic               idle_like, load_we, start_go, move_new;
   logic               nb_any, grow_hit, recolor_we;
   logic               check_win, check_lose;
   logic [CNT_W-1:0]   area;

   assign idle_like  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
   assign load_we    = LOAD_EN && idle_like && (LOAD_ROW < MAX_IDX) && (LOAD_COL < MAX_IDX);
   assign start_go   = START && idle_like;
   assign move_new   = MOVE_VALID && (state_reg == ST_PLAY) && (MOVE_COLOR != cur_reg);
   assign sw_en      = (state_reg == ST_GROW) || (state_reg == ST_RECOLOR);
   assign area       = CNT_W'(size_reg) * CNT_W'(size_reg);
   assign check_win  = (flood_cnt_reg == area);
   assign check_lose = (moves_reg == move_max_reg) && (move_max_reg != '0);

   flood_sweep_ctr u_sweep (
      .clk   (FAST_CLOCK),
      .rst_n (RESET_N),
      .en    (sw_en),
      .size  (size_reg),
      .row   (sw_row),
      .col   (sw_col),
      .last  (sw_last)
   );

   // Neighbours come straight from the mask registers, so cells flooded
   // earlier in the same sweep already propagate forward.
   always_comb begin
      nb_any = 1'b0;
      if (sw_row != '0)
         nb_any = nb_any | flooded_reg[sw_row - idx_t'(1)][sw_col];
      if (sw_row + idx_t'(1) < size_reg)
         nb_any = nb_any | flooded_reg[sw_row + idx_t'(1)][sw_col];
      if (sw_col != '0)
         nb_any = nb_any | flooded_reg[sw_row][sw_col - idx_t'(1)];
      if (sw_col + idx_t'(1) < size_reg)
         nb_any = nb_any | flooded_reg[sw_row][sw_col + idx_t'(1)];
   end

   assign grow_hit   = (state_reg == ST_GROW) && !flooded_reg[sw_row][sw_col] &&
                       (color_reg[sw_row][sw_col] == cur_reg) && nb_any;
   assign recolor_we = (state_reg == ST_RECOLOR) && flooded_reg[sw_row][sw_col];

   assign RD_COLOR = ((RD_ROW < size_reg) && (RD_COL < size_reg)) ?
                     color_reg[RD_ROW][RD_COL] : '0;

   always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int r = 0; r < MAX_SIZE; r++) begin
            for (int c = 0; c < MAX_SIZE; c++) begin
               color_reg[r][c]   <= '0;
               flooded_reg[r][c] <= 1'b0;
            end
         end
      end else begin
         if (load_we)
            color_reg[LOAD_ROW][LOAD_COL] <= LOAD_COLOR;
         if (recolor_we)
            color_reg[sw_row][sw_col] <= cur_reg;
         if (start_go) begin
            for (int r = 0; r < MAX_SIZE; r++) begin
               for (int c = 0; c < MAX_SIZE; c++) begin
                  flooded_reg[r][c] <= 1'b0;
               end
            end
            flooded_reg[0][0] <= 1'b1;
         end else if (grow_hit) begin
            flooded_reg[sw_row][sw_col] <= 1'b1;
         end
      end
   end

   always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg     <= ST_IDLE;
         size_reg      <= '0;
         move_max_reg  <= '0;
         moves_reg     <= '0;
         cur_reg       <= '0;
         flood_cnt_reg <= '0;
         changed_reg   <= 1'b0;
         won_reg       <= 1'b0;
         lost_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start_go) begin
            size_reg      <= clamp_size(SIZE);
            move_max_reg  <= MOVE_MAX;
            moves_reg     <= '0;
            cur_reg       <= color_reg[0][0];
            flood_cnt_reg <= CNT_W'(1);
            changed_reg   <= 1'b0;
            won_reg       <= 1'b0;
            lost_reg      <= 1'b0;
         end else begin
            if (move_new) begin
               cur_reg <= MOVE_COLOR;
               if (moves_reg != '1)
                  moves_reg <= moves_reg + MOVE_W'(1);
            end
            if (grow_hit)
               flood_cnt_reg <= flood_cnt_reg + CNT_W'(1);
            if (sw_en && sw_last)
               changed_reg <= 1'b0;
            else if (grow_hit)
               changed_reg <= 1'b1;
            // Win outranks loss when the final permitted move floods the board.
            if (state_reg == ST_CHECK) begin
               won_reg  <= check_win;
               lost_reg <= !check_win && check_lose;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      MOVE_READY = 1'b0;
      BUSY       = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start_go)
               state_next = ST_GROW;
         end
         ST_GROW: begin
            BUSY = 1'b1;
            if (sw_last)
               state_next = (changed_reg || grow_hit) ? ST_GROW : ST_CHECK;
         end
         ST_PLAY: begin
            MOVE_READY = 1'b1;
            if (move_new)
               state_next = ST_RECOLOR;
         end
         ST_RECOLOR: begin
            BUSY = 1'b1;
            if (sw_last)
               state_next = ST_GROW;
         end
         ST_CHECK: begin
            state_next = (check_win || check_lose) ? ST_DONE : ST_PLAY;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign MOVES = moves_reg;
   assign WON   = won_reg;
   assign LOST  = lost_reg;

endmodule

// File: tb/tb_flood_fill_engine.sv
// Scoreboard bench for flood_fill_engine: each START/move pushes the expected
// settled result; a monitor pops it when the engine settles.
module tb_flood_fill_engine;
   import flood_pkg::*;

   localparam int MOVE_W = 6;

   logic              FAST_CLOCK = 1'b0;
   logic              RESET_N    = 1'b0;
   idx_t              SIZE       = '0;
   logic [MOVE_W-1:0] MOVE_MAX   = '0;
   logic              LOAD_EN    = 1'b0;
   idx_t              LOAD_ROW   = '0;
   idx_t              LOAD_COL   = '0;
   color_t            LOAD_COLOR = '0;
   logic              START      = 1'b0;
   logic              MOVE_VALID = 1'b0;
   color_t            MOVE_COLOR = '0;
   logic              MOVE_READY;
   idx_t              RD_ROW     = '0;
   idx_t              RD_COL     = '0;
   color_t            RD_COLOR;
   logic [MOVE_W-1:0] MOVES;
   logic              BUSY;
   logic              WON;
   logic              LOST;

   flood_fill_engine #(.MOVE_W(MOVE_W)) dut (
      .FAST_CLOCK (FAST_CLOCK),
      .RESET_N    (RESET_N),
      .SIZE       (SIZE),
      .MOVE_MAX   (MOVE_MAX),
      .LOAD_EN    (LOAD_EN),
      .LOAD_ROW   (LOAD_ROW),
      .LOAD_COL   (LOAD_COL),
      .LOAD_COLOR (LOAD_COLOR),
      .START      (START),
      .MOVE_VALID (MOVE_VALID),
      .MOVE_COLOR (MOVE_COLOR),
      .MOVE_READY (MOVE_READY),
      .RD_ROW     (RD_ROW),
      .RD_COL     (RD_COL),
      .RD_COLOR   (RD_COLOR),
      .MOVES      (MOVES),
      .BUSY       (BUSY),
      .WON        (WON),
      .LOST       (LOST)
   );

   always #5 FAST_CLOCK = ~FAST_CLOCK;

   int cyc = 0;
   always @(posedge FAST_CLOCK) cyc <= cyc + 1;

   typedef struct packed {
      logic won;
      logic lost;
      int   moves;
      int   lat;
      int   issue;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks   = 0;
   int    failures = 0;
   logic  prev_settled = 1'b0;

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic push(input string nm, input logic w, input logic l, input int mv, input int lat);
      exp_t e;
      e.won   = w;
      e.lost  = l;
      e.moves = mv;
      e.lat   = lat;
      e.issue = cyc + 1;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: a rising "settled" (ready, won or lost) ends one transaction.
   initial begin : monitor
      logic  now_settled;
      exp_t  e;
      string nm;
      forever begin
         @(posedge FAST_CLOCK);
         #1;
         now_settled = MOVE_READY | WON | LOST;
         if (now_settled && !prev_settled) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_settle actual=settled required=busy_or_idle at cycle %0d", cyc);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check({nm, "_won"},     int'(WON),   int'(e.won));
               check({nm, "_lost"},    int'(LOST),  int'(e.lost));
               check({nm, "_moves"},   int'(MOVES), e.moves);
               check({nm, "_latency"}, cyc - e.issue, e.lat);
               $display("settle %s: won=%0d lost=%0d moves=%0d latency=%0d", nm, WON, LOST, MOVES, cyc - e.issue);
            end
         end
         prev_settled = now_settled;
      end
   end

   function automatic int board_color(input int id, input int r, input int c);
      case (id)
         0:       return 2;
         1:       return (r == 0 && c == 0) ? 0 : 1;
         2:       return (r + c) % 2;
         3:       return ((r % 2 == 0) || (r == 1 && c == 4) || (r == 3 && c == 0)) ? 1 : 0;
         default: return (r == 0) ? 3 : ((r == 1) ? 5 : 7);
      endcase
   endfunction

   task automatic load_board(input int id, input int n);
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c < n; c++) begin
            LOAD_EN    = 1'b1;
            LOAD_ROW   = idx_t'(r);
            LOAD_COL   = idx_t'(c);
            LOAD_COLOR = color_t'(board_color(id, r, c));
            @(negedge FAST_CLOCK);
         end
      end
      LOAD_EN = 1'b0;
   endtask

   task automatic start_game(input int n, input int mmax, input string nm,
                             input logic w, input logic l, input int mv, input int lat);
      SIZE     = idx_t'(n);
      MOVE_MAX = MOVE_W'(mmax);
      START    = 1'b1;
      push(nm, w, l, mv, lat);
      @(negedge FAST_CLOCK);
      START = 1'b0;
   endtask

   task automatic do_move(input int color, input logic do_push, input string nm,
                          input logic w, input logic l, input int mv, input int lat);
      int budget = 0;
      while (!MOVE_READY && budget < 2000) begin
         @(negedge FAST_CLOCK);
         budget++;
      end
      if (!MOVE_READY) begin
         checks++;
         failures++;
         $display("FAIL %s_ready_timeout actual=0 required=1", nm);
      end
      MOVE_VALID = 1'b1;
      MOVE_COLOR = color_t'(color);
      if (do_push) push(nm, w, l, mv, lat);
      @(negedge FAST_CLOCK);
      MOVE_VALID = 1'b0;
   endtask

   task automatic wait_settle(input string nm);
      int budget = 0;
      while (exp_q.size() != 0 && budget < 3000) begin
         @(negedge FAST_CLOCK);
         budget++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_settle_timeout actual_pending=%0d required=0", nm, exp_q.size());
         exp_q.delete();
         name_q.delete();
      end
   endtask

   task automatic rd(input int r, input int c, output int v);
      RD_ROW = idx_t'(r);
      RD_COL = idx_t'(c);
      #1;
      v = int'(RD_COLOR);
   endtask

   task automatic check_zero_outputs(input string nm);
      check({nm, "_ready"}, int'(MOVE_READY), 0);
      check({nm, "_busy"},  int'(BUSY),       0);
      check({nm, "_won"},   int'(WON),        0);
      check({nm, "_lost"},  int'(LOST),       0);
      check({nm, "_moves"}, int'(MOVES),      0);
   endtask

   initial begin : stimulus
      int v;
      int nonzero;

      // Reset state
      repeat (3) @(negedge FAST_CLOCK);
      check_zero_outputs("reset");
      rd(0, 0, v);
      check("reset_rd00", v, 0);
      RESET_N = 1'b1;
      @(negedge FAST_CLOCK);

      // 3x3 uniform board wins during initial growth: two sweeps plus CHECK
      load_board(0, 3);
      start_game(3, 0, "uniform_start", 1'b1, 1'b0, 0, 19);
      wait_settle("uniform_start");

      // One move floods everything; win outranks hitting MOVE_MAX=1
      load_board(1, 3);
      start_game(3, 1, "corner_start", 1'b0, 1'b0, 0, 10);
      wait_settle("corner_start");
      do_move(1, 1'b1, "corner_move1", 1'b1, 1'b0, 1, 28);
      wait_settle("corner_move1");
      @(negedge FAST_CLOCK);
      rd(0, 0, v);
      check("corner_rd00", v, 1);

      // Requests while busy are not captured; same-colour move is a no-op
      load_board(1, 3);
      start_game(3, 0, "noop_start", 1'b0, 1'b0, 0, 10);
      MOVE_VALID = 1'b1;
      MOVE_COLOR = color_t'(1);
      @(negedge FAST_CLOCK);
      check("busy_req_busy",  int'(BUSY),       1);
      check("busy_req_ready", int'(MOVE_READY), 0);
      repeat (3) @(negedge FAST_CLOCK);
      MOVE_VALID = 1'b0;
      wait_settle("noop_start");
      @(negedge FAST_CLOCK);
      check("noop_moves_after_busy_req", int'(MOVES), 0);
      rd(0, 0, v);
      check("noop_rd00_unchanged", v, 0);
      LOAD_EN    = 1'b1;
      LOAD_ROW   = '0;
      LOAD_COL   = '0;
      LOAD_COLOR = color_t'(5);
      @(negedge FAST_CLOCK);
      LOAD_EN = 1'b0;
      rd(0, 0, v);
      check("play_load_ignored", v, 0);
      @(negedge FAST_CLOCK);
      do_move(0, 1'b0, "noop_move0", 1'b0, 1'b0, 0, 0);
      repeat (3) @(negedge FAST_CLOCK);
      check("noop_ready", int'(MOVE_READY), 1);
      check("noop_moves", int'(MOVES),      0);
      check("noop_busy",  int'(BUSY),       0);
      do_move(1, 1'b1, "noop_move1", 1'b1, 1'b0, 1, 28);
      wait_settle("noop_move1");

      // 4x4 checkerboard, limit 1: region grows to three cells, then LOST
      load_board(2, 4);
      start_game(4, 1, "checker_start", 1'b0, 1'b0, 0, 17);
      wait_settle("checker_start");
      do_move(1, 1'b1, "checker_move1", 1'b0, 1'b1, 1, 49);
      wait_settle("checker_move1");
      @(negedge FAST_CLOCK);
      rd(0, 1, v); check("checker_rd01", v, 1);
      rd(1, 0, v); check("checker_rd10", v, 1);
      rd(1, 1, v); check("checker_rd11", v, 0);
      rd(0, 2, v); check("checker_rd02", v, 0);
      MOVE_VALID = 1'b1;
      MOVE_COLOR = color_t'(0);
      repeat (3) @(negedge FAST_CLOCK);
      MOVE_VALID = 1'b0;
      check("done_moves_held", int'(MOVES),      1);
      check("done_lost_held",  int'(LOST),       1);
      check("done_won_held",   int'(WON),        0);
      check("done_not_ready",  int'(MOVE_READY), 0);
      rd(1, 1, v); check("done_rd11", v, 0);

      // 5x5 serpentine: five changing sweeps plus a quiet one before PLAY
      load_board(3, 5);
      start_game(5, 0, "serp_start", 1'b0, 1'b0, 0, 151);
      wait_settle("serp_start");
      do_move(0, 1'b1, "serp_move0", 1'b1, 1'b0, 1, 76);
      wait_settle("serp_move0");

      // 26x26 board, reset dropped in the middle of RECOLOR
      load_board(1, 26);
      start_game(26, 0, "big_start", 1'b0, 1'b0, 0, 677);
      wait_settle("big_start");
      do_move(1, 1'b0, "big_move1", 1'b0, 1'b0, 0, 0);
      repeat (100) @(negedge FAST_CLOCK);
      check("big_busy_recolor", int'(BUSY), 1);
      RESET_N = 1'b0;
      #1;
      check_zero_outputs("midsweep_reset");
      nonzero = 0;
      for (int r = 0; r < 26; r++) begin
         for (int c = 0; c < 26; c++) begin
            rd(r, c, v);
            if (v != 0) nonzero++;
         end
      end
      check("midsweep_reset_rd_nonzero_cells", nonzero, 0);
      @(negedge FAST_CLOCK);
      @(negedge FAST_CLOCK);
      RESET_N = 1'b1;
      @(negedge FAST_CLOCK);

      // Reload after reset; SIZE=1 clamps to a 2x2 game
      load_board(4, 3);
      start_game(1, 0, "clamp_start", 1'b0, 1'b0, 0, 9);
      wait_settle("clamp_start");
      @(negedge FAST_CLOCK);
      rd(0, 0, v); check("clamp_rd00", v, 3);
      rd(2, 2, v); check("clamp_rd22_outside", v, 0);
      do_move(5, 1'b1, "clamp_move5", 1'b1, 1'b0, 1, 13);
      wait_settle("clamp_move5");
      @(negedge FAST_CLOCK);
      rd(1, 1, v); check("clamp_rd11", v, 5);
      rd(0, 1, v); check("clamp_rd01", v, 5);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
